// File: rtl/prog_loader_pkg.sv
// Shared types and defaults for the program loader.
// Holds the FSM state enum, size defaults and the word-packing order.
package prog_loader_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int NIB_W_DEF  = 4;
    localparam int DEPTH_DEF  = 16;

    // First nibble of each word goes to FUNCAO, second to data.
    localparam bit FUNC_FIRST = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_FUNC,
        ST_LOAD_DATA,
        ST_WRITE,
        ST_CHECK,
        ST_DONE
    } state_t;

endpackage

// File: rtl/prog_loader_load_counter.sv
// Word counter for the loader: clear/enable, terminal compare vs len.
// Ports: i_clk, i_rst, i_clr, i_en, i_len -> o_count, o_last.
module load_counter #(
    parameter int ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [ADDR_W:0]   i_len,
    output logic [ADDR_W:0]   o_count,
    output logic              o_last
);

    logic [ADDR_W:0]   r_cnt;
    logic [ADDR_W+1:0] w_next;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // One bit wider so count+1 cannot overflow before the compare.
    assign w_next  = {1'b0, r_cnt} + (ADDR_W+2)'(1);
    assign o_last  = (w_next >= {1'b0, i_len});
    assign o_count = r_cnt;

endmodule

// File: rtl/prog_loader.sv
// Program loader: packs a nibble stream into instruction memory words.
// Ports: clk, rst, start, len, in_valid/in_data/in_ready, mem_we,
// mem_addr, mem_funcao, mem_data, cpu_hold, busy, done, count, err.
// Optional checksum nibble after the last word: PROG_LOADER_CHECKSUM_EN.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NIB_W  = NIB_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              in_valid,
    input  logic [NIB_W-1:0]  in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [NIB_W-1:0]  mem_funcao,
    output logic [NIB_W-1:0]  mem_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic              err
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_t             r_state;
    logic [ADDR_W:0]    r_len;
    logic [NIB_W-1:0]   r_funcao;
    logic [NIB_W-1:0]   r_data;
    logic [ADDR_W:0]    w_len_sat;
    logic [ADDR_W:0]    w_count;
    logic               w_ready;
    logic               w_xfer;
    logic               w_clr;
    logic               w_en;
    logic               w_last;

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [NIB_W-1:0]   r_xor;
    logic               r_err;
`endif

    assign w_len_sat = (len > DEPTH_L) ? DEPTH_L : len;

    assign w_ready = (r_state == ST_LOAD_FUNC) ||
                     (r_state == ST_LOAD_DATA) ||
                     (r_state == ST_CHECK);
    assign w_xfer  = w_ready && in_valid;
    assign w_clr   = (r_state == ST_IDLE) && start;
    assign w_en    = (r_state == ST_WRITE);

    load_counter #(
        .ADDR_W (ADDR_W)
    ) u_cnt (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_clr   (w_clr),
        .i_en    (w_en),
        .i_len   (r_len),
        .o_count (w_count),
        .o_last  (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_len    <= '0;
            r_funcao <= '0;
            r_data   <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_xor    <= '0;
            r_err    <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_len <= w_len_sat;
`ifdef PROG_LOADER_CHECKSUM_EN
                        r_xor <= '0;
                        r_err <= 1'b0;
`endif
                        if (len == '0) r_state <= ST_DONE;
                        else           r_state <= ST_LOAD_FUNC;
                    end
                end
                ST_LOAD_FUNC: begin
                    if (w_xfer) begin
                        if (FUNC_FIRST) r_funcao <= in_data;
                        else            r_data   <= in_data;
`ifdef PROG_LOADER_CHECKSUM_EN
                        r_xor <= r_xor ^ in_data;
`endif
                        r_state <= ST_LOAD_DATA;
                    end
                end
                ST_LOAD_DATA: begin
                    if (w_xfer) begin
                        if (FUNC_FIRST) r_data   <= in_data;
                        else            r_funcao <= in_data;
`ifdef PROG_LOADER_CHECKSUM_EN
                        r_xor <= r_xor ^ in_data;
`endif
                        r_state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (!w_last) begin
                        r_state <= ST_LOAD_FUNC;
                    end else begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        r_state <= ST_CHECK;
`else
                        r_state <= ST_DONE;
`endif
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (w_xfer) begin
                        r_err   <= (in_data != r_xor);
                        r_state <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = w_ready;
    assign mem_we     = (r_state == ST_WRITE);
    assign mem_addr   = w_count[ADDR_W-1:0];
    assign mem_funcao = r_funcao;
    assign mem_data   = r_data;
    assign busy       = (r_state != ST_IDLE);
    assign cpu_hold   = (r_state != ST_IDLE);
    assign done       = (r_state == ST_DONE);
    assign count      = w_count;

`ifdef PROG_LOADER_CHECKSUM_EN
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader.
// Expected words, timing and flags come from a list-based load model.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] len;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [3:0] mem_funcao;
    logic [3:0] mem_data;
    logic       cpu_hold;
    logic       busy;
    logic       done;
    logic [4:0] count;
    logic       err;

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    prog_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_funcao (mem_funcao),
        .mem_data   (mem_data),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .count      (count),
        .err        (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int a;
        int f;
        int d;
    } wr_t;

    wr_t wr_q[$];
    int  done_q[$];

    always @(negedge clk) begin
        if (mem_we)
            wr_q.push_back('{int'(mem_addr), int'(mem_funcao),
                             int'(mem_data)});
        if (done) done_q.push_back(cyc);
    end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int dir_f[16];
    int dir_d[16];

    // Present one nibble: wait for ready, stall, then hold valid one cycle.
    task automatic feed_nib(input int v, input int stall);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("ready_wait", in_ready, 1);
        repeat (stall) begin
            @(negedge clk);
            check("ready_stall", in_ready, 1);
        end
        in_valid = 1'b1;
        in_data  = 4'(v);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // fixed: use dir_f/dir_d words; fstall>=0: stall only before nibble 1.
    task automatic run_load(input int L, input bit fixed, input int smax,
                            input int fstall, input bit restart,
                            input bit bad_ck);
        int n;
        int nib[$];
        int x;
        int total;
        int c0;
        int s;
        int w;
        int ef[16];
        int ed[16];
        int exp_err;
        n = (L > 16) ? 16 : L;
        x = 0;
        total = 0;
        for (int i = 0; i < n; i++) begin
            ef[i] = fixed ? dir_f[i] : int'($urandom_range(0, 15));
            ed[i] = fixed ? dir_d[i] : int'($urandom_range(0, 15));
            nib.push_back(ef[i]);
            nib.push_back(ed[i]);
            x = x ^ ef[i] ^ ed[i];
        end
        exp_err = 0;
        if (CK && n > 0) begin
            if (bad_ck) begin
                nib.push_back(x ^ int'($urandom_range(1, 15)));
                exp_err = 1;
            end else begin
                nib.push_back(x);
            end
            total = 1;
        end
        wr_q.delete();
        done_q.delete();
        start = 1'b1;
        len   = 5'(L);
        @(negedge clk);
        start = 1'b0;
        c0 = cyc;
        check("hold_rise", cpu_hold, 1);
        check("busy_rise", busy, 1);
        check("err_clr", err, 0);
        foreach (nib[k]) begin
            if (fstall >= 0) s = (k == 1) ? fstall : 0;
            else             s = int'($urandom_range(0, smax));
            total += s;
            if (restart && k == 1) begin
                start = 1'b1;
                len   = 5'($urandom_range(0, 31));
            end
            feed_nib(nib[k], s);
            start = 1'b0;
        end
        w = 0;
        while (!done && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("done_seen", done, 1);
        check("done_cycle", cyc - c0, 3 * n + total);
        check("count", count, n);
        check("addr_end", mem_addr, n % 16);
        check("hold_done", cpu_hold, 1);
        @(negedge clk);
        check("hold_fall", cpu_hold, 0);
        check("busy_fall", busy, 0);
        check("done_pulse", done, 0);
        check("ready_idle", in_ready, 0);
        repeat (3) @(negedge clk);
        check("err", err, exp_err);
        check("n_done", done_q.size(), 1);
        check("n_write", wr_q.size(), n);
        for (int i = 0; i < n && i < wr_q.size(); i++) begin
            check("wr_addr", wr_q[i].a, i);
            check("wr_func", wr_q[i].f, ef[i]);
            check("wr_data", wr_q[i].d, ed[i]);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ready"}, in_ready, 0);
        check({tag, "_we"}, mem_we, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_func"}, mem_funcao, 0);
        check({tag, "_data"}, mem_data, 0);
        check({tag, "_hold"}, cpu_hold, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_count"}, count, 0);
        check({tag, "_err"}, err, 0);
    endtask

    task automatic reset_mid_load();
        wr_q.delete();
        done_q.delete();
        start = 1'b1;
        len   = 5'd3;
        @(negedge clk);
        start = 1'b0;
        feed_nib(4'hC, 0);
        feed_nib(4'h4, 0);
        feed_nib(4'hB, 0);
        check("mid_ready", in_ready, 1);
        rst = 1'b1;
        @(negedge clk);
        check_zero("rst_mid");
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_hold", cpu_hold, 0);
        check("rst_n_done", done_q.size(), 0);
        check("rst_n_write", wr_q.size(), 1);
        if (wr_q.size() > 0) begin
            check("rst_w_addr", wr_q[0].a, 0);
            check("rst_w_func", wr_q[0].f, 12);
            check("rst_w_data", wr_q[0].d, 4);
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        len      = '0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        dir_f[0] = 3;  dir_d[0] = 7;
        dir_f[1] = 10; dir_d[1] = 5;
        run_load(2, 1'b1, 0, 0, 1'b0, 1'b0);

        run_load(0, 1'b0, 0, 0, 1'b0, 1'b0);

        dir_f[0] = 2; dir_d[0] = 9;
        run_load(1, 1'b1, 0, 4, 1'b0, 1'b0);

        reset_mid_load();

        run_load(3, 1'b0, 1, -1, 1'b1, 1'b0);

        dir_f[0] = 5; dir_d[0] = 3;
        run_load(1, 1'b1, 0, 0, 1'b0, 1'b0);
        run_load(1, 1'b1, 0, 0, 1'b0, 1'b1);

        run_load(16, 1'b0, 0, -1, 1'b0, 1'b0);
        run_load(20, 1'b0, 1, -1, 1'b0, 1'b1);

        for (int t = 0; t < 12; t++) begin
            run_load(int'($urandom_range(0, 31)), 1'b0, 2, -1,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Program loader for the 4-bit accumulator-style datapath: the writer side of the instruction memory that the PC/control path reads. It accepts a stream of nibbles over a valid/ready handshake and packs each pair into one memory word (FUNCAO nibble, then data nibble). It writes the words to consecutive addresses starting at 0 and holds the CPU while loading. When the load completes it releases the CPU so the PC starts from a freshly written program.

## Interface
Parameters:
- ADDR_W, 4, memory address width
- NIB_W, 4, width of FUNCAO and data fields
- DEPTH, 16, number of memory words (2**ADDR_W)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a load; sampled only in IDLE
- len  input  ADDR_W+1  number of words to load, sampled with start
- in_valid  input  1  in_data holds a nibble
- in_data  input  NIB_W  nibble stream
- in_ready  output  1  loader accepts a nibble this cycle
- mem_we  output  1  write strobe to instruction memory
- mem_addr  output  ADDR_W  write address
- mem_funcao  output  NIB_W  FUNCAO field of word being written
- mem_data  output  NIB_W  data field of word being written
- cpu_hold  output  1  stall/clear request to PC and Control
- busy  output  1  loader not in IDLE
- done  output  1  one-cycle pulse at end of load
- count  output  ADDR_W+1  words written in current/last load
- err  output  1  checksum mismatch flag (see Configuration)

## Operation
- States: IDLE, LOAD_FUNC, LOAD_DATA, WRITE, CHECK (macro only), DONE.
- IDLE:
  - start=1 latches len, clears count, mem_addr and err.
  - len=0 goes to DONE; otherwise goes to LOAD_FUNC.
  - len>DEPTH saturates to DEPTH.
- Transfer: occurs on an edge with in_valid && in_ready. in_ready=1 only in LOAD_FUNC, LOAD_DATA and CHECK.
- LOAD_FUNC: a transfer captures mem_funcao and moves to LOAD_DATA.
- LOAD_DATA: a transfer captures mem_data and moves to WRITE.
- WRITE:
  - mem_we=1 for exactly one cycle; mem_addr, mem_funcao and mem_data are stable during it.
  - On exit, mem_addr increments and count increments.
  - Exits to LOAD_FUNC if count+1 < len.
  - Otherwise exits to CHECK if the macro is defined, or DONE if not.
- DONE: done=1 for one cycle, then IDLE.
- cpu_hold = busy = 1 in every state except IDLE.
- start while busy is ignored. in_valid while in_ready=0 is ignored; the nibble is not consumed.
- mem_addr wrap: at most DEPTH words are written, so mem_addr never wraps within a load. After a full load of DEPTH words it reads 0.
- Reset values: all outputs 0 and state IDLE.
- Reset mid-load:
  - Immediate return to IDLE; memory words already written are left as-is.
  - done is not pulsed and cpu_hold drops.

## Timing
- Every output is driven from registers or from state decode only; no combinational input-to-output path.
- in_ready depends on state only.
- With in_valid held high, one word takes 3 cycles: LOAD_FUNC, LOAD_DATA, WRITE.
- Let edge 0 be the start edge. Without the macro, done is high in the cycle after edge 3N; with it, after edge 3N+1.
- len=0: done is high in the cycle after edge 0.
- cpu_hold rises in the cycle after the start edge and falls in the cycle after the done cycle.
- Stalls (in_valid=0) extend LOAD_FUNC/LOAD_DATA/CHECK indefinitely with no state change.

## Configuration
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of every captured nibble (FUNCAO and data) is kept.
  - After the last WRITE, CHECK accepts one extra nibble. err=1 if it differs from the running XOR, else err=0.
  - err holds until the next accepted start or rst.
  - DONE follows CHECK regardless of the result.
- Undefined: no CHECK state, err tied 0, no extra nibble consumed.

## Structure
- Shared package holds:
  - the state enum;
  - ADDR_W, NIB_W and DEPTH defaults;
  - the word-packing order constant (FUNCAO first).
- One sub-module: load_counter, a resettable ADDR_W+1 counter with clear/enable and a terminal-count compare against len.
  - It provides mem_addr/count and the last-word signal, mirroring the PC counter.

## Test plan
- len=2, in_valid=1, nibbles 3,7,A,5:
  - mem_we in 2 cycles, writing addr0={3,7} and addr1={A,5};
  - done in the cycle after edge 6; count=2.
- len=0: no mem_we, done one cycle after start, cpu_hold=1 for exactly that cycle.
- len=1 with in_valid low 4 cycles between nibbles 2 and 9:
  - in_ready stays 1 and no extra capture;
  - word {2,9} written at addr0; done delayed 4 cycles.
- rst asserted in LOAD_DATA of word 1 of a len=3 load: next cycle all outputs 0 and state IDLE; addr0 remains written, no done pulse.
- start pulsed again while busy: ignored, original load completes with the original len.
- Macro defined, len=1, nibbles 5,3:
  - checksum nibble 6 gives err=0, done after edge 4;
  - checksum nibble 0 gives err=1, which holds until the next start.
